// File: rtl/md_unit_if.sv
// Bus between the execute stage and the HI/LO multiply-divide unit.
// start is a one-cycle request, taken only while busy=0; busy is high from
// the accepting edge until the completion edge, when hi/lo change together.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  modport master (
    output start, md_op, a, b,
    input  busy, hi, lo, dbg_state
  );

  modport slave (
    input  start, md_op, a, b,
    output busy, hi, lo, dbg_state
  );
endinterface

// File: rtl/md_unit.sv
// HI/LO multiply-divide unit: fixed-latency mult/div with a busy window,
// plus single-cycle mthi/mtlo writes. hi/lo are registered outputs.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      hi_q, lo_q, hi_n, lo_n;
  logic             latch_en;

  // Datapath works only on the operands captured at the accepting edge.
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0]        prod_u, mul_res;
  logic               mul_op, div_signed, a_neg, b_neg, div_by_zero;
  logic [31:0]        a_mag, b_mag, divisor, quo_mag, rem_mag, quo, rem;

  assign a_sx   = {{32{a_q[31]}}, a_q};
  assign b_sx   = {{32{b_q[31]}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  assign mul_op  = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign mul_res = (op_q == OP_MULT) ? prod_s : prod_u;

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // follows the dividend. 0x80000000 / -1 wraps back to 0x80000000.
  assign div_signed  = (op_q == OP_DIV);
  assign a_neg       = div_signed & a_q[31];
  assign b_neg       = div_signed & b_q[31];
  assign a_mag       = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag       = b_neg ? (~b_q + 32'd1) : b_q;
  assign div_by_zero = (b_q == 32'd0);
  assign divisor     = div_by_zero ? 32'd1 : b_mag;
  assign quo_mag     = a_mag / divisor;
  assign rem_mag     = a_mag % divisor;
  assign quo         = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem         = a_neg ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hi_n     = hi_q;
    lo_n     = lo_q;
    latch_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.md_op)
            OP_MULT, OP_MULTU: begin
              latch_en = 1'b1;
              cnt_n    = MULT_LOAD;
              state_n  = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              latch_en = 1'b1;
              cnt_n    = DIV_LOAD;
              state_n  = S_BUSY;
            end
            OP_MTHI: hi_n = bus.a;
            OP_MTLO: lo_n = bus.a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_n = cnt - CNT_ONE;
        // <= also covers a zero load so a zero-cycle parameter cannot wrap.
        if (cnt <= CNT_ONE) begin
          cnt_n   = '0;
          state_n = S_IDLE;
          if (mul_op) begin
            {hi_n, lo_n} = mul_res;
          end else if (!div_by_zero) begin
            hi_n = rem;
            lo_n = quo;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (latch_en) begin
        op_q <= bus.md_op;
        a_q  <= bus.a;
        b_q  <= bus.b;
      end
    end
  end

  assign bus.busy      = (state == S_BUSY);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_md_unit.sv
// Randomized bench for md_unit: driver pushes expected {latency,hi,lo} from a
// plain-arithmetic model; a negedge monitor pops and compares on each commit.
module tb_md_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard state: item = {latency[7:0], hi[31:0], lo[31:0]}, latency 0 = immediate
  logic [71:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          imm_cnt  = 0;
  int          imm_seen = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  logic        prev_busy = 1'b0;
  int          bcyc      = 0;
  logic [31:0] ref_hi    = 32'd0;
  logic [31:0] ref_lo    = 32'd0;
  logic [71:0] item;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] model(input logic [2:0] op, input logic [31:0] av,
                                        input logic [31:0] bv, input logic [31:0] hv,
                                        input logic [31:0] lv);
    longint      sp, sq, sr;
    logic [63:0] up;
    case (op)
      3'd1: begin
        sp = longint'($signed(av)) * longint'($signed(bv));
        return {8'(MULT_LAT), 64'(sp)};
      end
      3'd2: begin
        up = {32'd0, av} * {32'd0, bv};
        return {8'(MULT_LAT), up};
      end
      3'd3: begin
        if (bv == 32'd0) return {8'(DIV_LAT), hv, lv};
        sq = longint'($signed(av)) / longint'($signed(bv));
        sr = longint'($signed(av)) % longint'($signed(bv));
        return {8'(DIV_LAT), sr[31:0], sq[31:0]};
      end
      3'd4: begin
        if (bv == 32'd0) return {8'(DIV_LAT), hv, lv};
        return {8'(DIV_LAT), av % bv, av / bv};
      end
      3'd5:    return {8'd0, av, lv};
      3'd6:    return {8'd0, hv, av};
      default: return {8'd0, hv, lv};
    endcase
  endfunction

  // driver tasks: called at posedge+1
  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.start = 1'b1;
        bus.md_op = 3'($urandom_range(0, 7));
      end else begin
        bus.start = 1'b0;
      end
      bus.a = $urandom;
      bus.b = $urandom;
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=busy_after_%0d_cycles required=idle", n);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input bit do_wait);
    logic [71:0] e;
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.md_op = 3'($urandom_range(0, 7));
    bus.a     = $urandom;
    bus.b     = $urandom;
    e = model(op, av, bv, model_hi, model_lo);
    model_hi = e[63:32];
    model_lo = e[31:0];
    exp_q.push_back(e);
    if (e[71:64] == 8'd0) imm_cnt++;
    else if (do_wait) wait_idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back(72'd0);
    imm_cnt++;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // monitor: commits are a busy fall or an immediate op the driver announced
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        bcyc      = 0;
        ref_hi    = 32'd0;
        ref_lo    = 32'd0;
      end else begin
        if (bus.busy === 1'b1) begin
          bcyc++;
          check("hold_during_busy", {bus.hi, bus.lo}, {ref_hi, ref_lo});
        end else if (prev_busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_commit actual=commit required=none at %0t", $time);
          end else begin
            item = exp_q.pop_front();
            check("busy_cycles", 64'(bcyc), 64'(item[71:64]));
            check("result", {bus.hi, bus.lo}, item[63:0]);
            check("state_idle", 64'(bus.dbg_state), 64'd0);
            ref_hi = item[63:32];
            ref_lo = item[31:0];
          end
          bcyc = 0;
        end
        if (imm_cnt != imm_seen) begin
          imm_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL imm_missing actual=empty required=item at %0t", $time);
          end else begin
            item = exp_q.pop_front();
            check("imm_busy", 64'({bus.busy, bus.dbg_state}), 64'd0);
            check("imm_result", {bus.hi, bus.lo}, item[63:0]);
            ref_hi = item[63:32];
            ref_lo = item[31:0];
          end
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    #1;
    do_reset();

    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd4, 32'd7, 32'd2, 1'b1);
    issue(3'd5, 32'h1234_5678, 32'd0, 1'b1);
    issue(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b1);
    issue(3'd5, 32'hAAAA_0000, 32'd0, 1'b1);
    issue(3'd6, 32'h0000_BBBB, 32'd0, 1'b1);
    issue(3'd4, 32'h1234_0000, 32'd0, 1'b1);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(3'd0, 32'hDEAD_BEEF, 32'd1, 1'b1);
    issue(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b1);

    // a div requested during a mult's busy window must be dropped
    issue(3'd1, 32'h0001_0003, 32'hFFFF_0007, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.md_op = 3'd3;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();

    // abort a div part way, then start on the first edge after reset
    issue(3'd3, 32'h7654_3210, 32'd3, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    do_reset();
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 1'b1);
    end

    repeat (4) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("imm_all_seen", 64'(imm_seen), 64'(imm_cnt));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
